// File: rtl/theremin_sensor_pkg.sv
// Shared types for the theremin sensor path: the edge-measurement FSM states
// and the width of the sub-cycle edge position produced by the upstream detector.
package theremin_sensor_pkg;

   localparam int SUBCYCLE_BITS = 6;

   typedef enum logic [1:0] {
      WAIT_FIRST_RISE = 2'd0,
      WAIT_FALL       = 2'd1,
      WAIT_RISE       = 2'd2
   } meas_state_t;

endpackage

// File: rtl/edge_timestamp_counter.sv
// Free-running parallel-cycle counter; ts is {cycle, sub-cycle bit} for the current cycle.
// Latency: ts is combinational from the registered count; no backpressure.
module edge_timestamp_counter
   import theremin_sensor_pkg::*;
#(
   parameter int COUNTER_BITS = 26
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [SUBCYCLE_BITS-1:0]                changed_bit,
   output logic [COUNTER_BITS+SUBCYCLE_BITS-1:0]   ts
);

   logic [COUNTER_BITS-1:0] cyc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= '0;
      end else begin
         cyc <= cyc + 1'b1;
      end
   end

   // Uses the count before this cycle's increment.
   assign ts = {cyc, changed_bit};

endmodule

// File: rtl/edge_period_measure.sv
// Rise-to-rise period and rise-to-fall high time from sub-cycle edge flags; 1 CLK flag-to-strobe, no backpressure.
// EDGE_PERIOD_MEASURE_TIMEOUT_EN adds STALLED and an edge-loss timeout that restarts the measurement.
module edge_period_measure
   import theremin_sensor_pkg::*;
#(
   parameter int COUNTER_BITS   = 26,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                                    CLK,
   input  logic                                    RESETN,
   input  logic                                    CHANGED_FLAG,
   input  logic [SUBCYCLE_BITS-1:0]                CHANGED_BIT,
   output logic [COUNTER_BITS+SUBCYCLE_BITS-1:0]   PERIOD,
   output logic [COUNTER_BITS+SUBCYCLE_BITS-1:0]   HIGH_TIME,
   output logic                                    PERIOD_VALID
`ifdef EDGE_PERIOD_MEASURE_TIMEOUT_EN
   ,
   output logic                                    STALLED
`endif
);

   localparam int TS_W = COUNTER_BITS + SUBCYCLE_BITS;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] rise_ts;
   logic [TS_W-1:0] high_pend;
   meas_state_t     state;

`ifdef EDGE_PERIOD_MEASURE_TIMEOUT_EN
   logic [31:0]     to_cnt;
`endif

   edge_timestamp_counter #(
      .COUNTER_BITS (COUNTER_BITS)
   ) u_ts (
      .clk         (CLK),
      .rst_n       (RESETN),
      .changed_bit (CHANGED_BIT),
      .ts          (ts)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state        <= WAIT_FIRST_RISE;
         rise_ts      <= '0;
         high_pend    <= '0;
         PERIOD       <= '0;
         HIGH_TIME    <= '0;
         PERIOD_VALID <= 1'b0;
`ifdef EDGE_PERIOD_MEASURE_TIMEOUT_EN
         to_cnt       <= '0;
         STALLED      <= 1'b0;
`endif
      end else begin
         PERIOD_VALID <= 1'b0;
         if (CHANGED_FLAG) begin
            // Differences are modular, so a counter wrap between edges is harmless.
            case (state)
               WAIT_FIRST_RISE: begin
                  rise_ts <= ts;
                  state   <= WAIT_FALL;
               end
               WAIT_FALL: begin
                  high_pend <= ts - rise_ts;
                  state     <= WAIT_RISE;
               end
               WAIT_RISE: begin
                  PERIOD       <= ts - rise_ts;
                  HIGH_TIME    <= high_pend;
                  PERIOD_VALID <= 1'b1;
                  rise_ts      <= ts;
                  state        <= WAIT_FALL;
               end
               default: state <= WAIT_FIRST_RISE;
            endcase
         end
`ifdef EDGE_PERIOD_MEASURE_TIMEOUT_EN
         // Only a measurement in progress can lose edges; an edge on the expiry cycle wins.
         if (CHANGED_FLAG) begin
            to_cnt  <= '0;
            STALLED <= 1'b0;
         end else if (state != WAIT_FIRST_RISE) begin
            if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
               to_cnt  <= '0;
               STALLED <= 1'b1;
               state   <= WAIT_FIRST_RISE;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule
